// File: rtl/mem_stage_wb.sv
// MEM stage: data memory behind a fixed-latency access FSM, branch resolution,
// and the MEM/WB pipeline register.
module mem_stage_wb #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemtoReg_MEM,
  input  logic              MemWrite_MEM,
  input  logic              MemRead_MEM,
  input  logic              Branch_MEM,
  input  logic              RegWrite_MEM,
  input  logic              Zero_MEM,
  input  logic              Overflow_MEM,
  input  logic [2:0]        BranchSt_MEM,
  input  logic [31:0]       ALUOut_MEM,
  input  logic [31:0]       ReadRt_MEM,
  input  logic [31:0]       PCBranch_MEM,
  input  logic [4:0]        WriteReg_MEM,
  output logic              PCSrc,
  output logic [31:0]       PCBranch,
  output logic              Flush,
  output logic              Stall,
  output logic              OvfExc,
  output logic              MemtoReg_WB,
  output logic              RegWrite_WB,
  output logic [31:0]       ReadData_WB,
  output logic [31:0]       ALUOut_WB,
  output logic [4:0]        WriteReg_WB
);

  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0]  idx;
  logic               store;
  logic               memop;
  logic               stall_int;
  logic               pass;
  logic               cond;

  assign idx   = ALUOut_MEM[ADDR_W+1:2];
  assign store = MemWrite_MEM & ~Overflow_MEM;
  assign memop = MemRead_MEM | store;

  always_comb begin
    stall_int = 1'b0;
    if (state == BUSY) stall_int = (cnt != '0);
    else               stall_int = memop && (MEM_LAT > 0);
  end

  // pass: the instruction in MEM moves into MEM/WB at this edge
  assign Stall = rst_n & stall_int;
  assign pass  = rst_n & ~stall_int;

  always_comb begin
    cond = 1'b0;
    case (BranchSt_MEM)
      3'b000:  cond = Zero_MEM;
      3'b001:  cond = ~Zero_MEM;
      3'b010:  cond = ~ALUOut_MEM[31];
      3'b011:  cond = ~ALUOut_MEM[31] & ~Zero_MEM;
      3'b100:  cond = ALUOut_MEM[31] | Zero_MEM;
      3'b101:  cond = ALUOut_MEM[31];
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc    = rst_n & Branch_MEM & cond & ~stall_int;
  assign Flush    = PCSrc;
  assign PCBranch = PCBranch_MEM;

  // Memory contents survive reset; a store aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (pass && store) mem[idx] <= ReadRt_MEM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      OvfExc      <= 1'b0;
      MemtoReg_WB <= 1'b0;
      RegWrite_WB <= 1'b0;
      ReadData_WB <= '0;
      ALUOut_WB   <= '0;
      WriteReg_WB <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && (MEM_LAT > 0)) begin
            state <= BUSY;
            cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pass) begin
        MemtoReg_WB <= MemtoReg_MEM;
        RegWrite_WB <= RegWrite_MEM & ~Overflow_MEM;
        ALUOut_WB   <= ALUOut_MEM;
        WriteReg_WB <= WriteReg_MEM;
        ReadData_WB <= MemRead_MEM ? mem[idx] : 32'h0;
        OvfExc      <= Overflow_MEM & RegWrite_MEM;
      end else begin
        MemtoReg_WB <= 1'b0;
        RegWrite_WB <= 1'b0;
        ALUOut_WB   <= '0;
        WriteReg_WB <= '0;
        ReadData_WB <= '0;
        OvfExc      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb: one MEM_LAT=2 instance and one MEM_LAT=0
// instance sharing the same MEM-stage inputs.
module tb_mem_stage_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoReg_MEM, MemWrite_MEM, MemRead_MEM, Branch_MEM;
  logic        RegWrite_MEM, Zero_MEM, Overflow_MEM;
  logic [2:0]  BranchSt_MEM;
  logic [31:0] ALUOut_MEM, ReadRt_MEM, PCBranch_MEM;
  logic [4:0]  WriteReg_MEM;

  logic        PCSrc, Flush, Stall, OvfExc, MemtoReg_WB, RegWrite_WB;
  logic [31:0] PCBranch, ReadData_WB, ALUOut_WB;
  logic [4:0]  WriteReg_WB;

  logic        z_PCSrc, z_Flush, z_Stall, z_OvfExc, z_MemtoReg_WB, z_RegWrite_WB;
  logic [31:0] z_PCBranch, z_ReadData_WB, z_ALUOut_WB;
  logic [4:0]  z_WriteReg_WB;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_wb #(.ADDR_W(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_MEM(MemtoReg_MEM), .MemWrite_MEM(MemWrite_MEM), .MemRead_MEM(MemRead_MEM),
    .Branch_MEM(Branch_MEM), .RegWrite_MEM(RegWrite_MEM), .Zero_MEM(Zero_MEM),
    .Overflow_MEM(Overflow_MEM), .BranchSt_MEM(BranchSt_MEM), .ALUOut_MEM(ALUOut_MEM),
    .ReadRt_MEM(ReadRt_MEM), .PCBranch_MEM(PCBranch_MEM), .WriteReg_MEM(WriteReg_MEM),
    .PCSrc(PCSrc), .PCBranch(PCBranch), .Flush(Flush), .Stall(Stall), .OvfExc(OvfExc),
    .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB), .ReadData_WB(ReadData_WB),
    .ALUOut_WB(ALUOut_WB), .WriteReg_WB(WriteReg_WB)
  );

  mem_stage_wb #(.ADDR_W(8), .MEM_LAT(0)) zdut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_MEM(MemtoReg_MEM), .MemWrite_MEM(MemWrite_MEM), .MemRead_MEM(MemRead_MEM),
    .Branch_MEM(Branch_MEM), .RegWrite_MEM(RegWrite_MEM), .Zero_MEM(Zero_MEM),
    .Overflow_MEM(Overflow_MEM), .BranchSt_MEM(BranchSt_MEM), .ALUOut_MEM(ALUOut_MEM),
    .ReadRt_MEM(ReadRt_MEM), .PCBranch_MEM(PCBranch_MEM), .WriteReg_MEM(WriteReg_MEM),
    .PCSrc(z_PCSrc), .PCBranch(z_PCBranch), .Flush(z_Flush), .Stall(z_Stall), .OvfExc(z_OvfExc),
    .MemtoReg_WB(z_MemtoReg_WB), .RegWrite_WB(z_RegWrite_WB), .ReadData_WB(z_ReadData_WB),
    .ALUOut_WB(z_ALUOut_WB), .WriteReg_WB(z_WriteReg_WB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    MemtoReg_MEM = 0; MemWrite_MEM = 0; MemRead_MEM = 0; Branch_MEM = 0;
    RegWrite_MEM = 0; Zero_MEM = 0; Overflow_MEM = 0; BranchSt_MEM = 3'b000;
    ALUOut_MEM = 0; ReadRt_MEM = 0; PCBranch_MEM = 0; WriteReg_MEM = 0;
  endtask

  // Counts stall cycles on the MEM_LAT=2 instance, then takes the completion edge.
  task automatic run_mem(input string tag, input int exp_stalls);
    int n = 0;
    while (Stall === 1'b1 && n < 20) begin
      n++;
      nxt();
    end
    check({tag, "_stalls"}, n, exp_stalls);
    nxt();
  endtask

  initial begin
    // Reset with random inputs (no branch, so PCSrc is unambiguous)
    rst_n = 0;
    clr();
    MemWrite_MEM = 1'($urandom); MemRead_MEM = 1'($urandom); RegWrite_MEM = 1'($urandom);
    MemtoReg_MEM = 1'($urandom); Overflow_MEM = 1'($urandom); Zero_MEM = 1'($urandom);
    ALUOut_MEM = $urandom; ReadRt_MEM = $urandom; WriteReg_MEM = 5'($urandom);
    repeat (2) nxt();
    check("rst_stall", Stall, 1'b0);
    check("rst_pcsrc", PCSrc, 1'b0);
    check("rst_ovf", OvfExc, 1'b0);
    check("rst_regwrite", RegWrite_WB, 1'b0);
    check("rst_memtoreg", MemtoReg_WB, 1'b0);
    check("rst_aluout", ALUOut_WB, 32'h0);
    check("rst_readdata", ReadData_WB, 32'h0);
    check("rst_writereg", WriteReg_WB, 5'd0);
    check("rst_z_stall", z_Stall, 1'b0);
    $display("[TB] reset checked");

    // First non-memory instruction after release: latency 1
    rst_n = 1;
    clr();
    RegWrite_MEM = 1; ALUOut_MEM = 32'h1234; WriteReg_MEM = 5'd3;
    #1 check("add_nostall", Stall, 1'b0);
    nxt();
    check("add_regwrite", RegWrite_WB, 1'b1);
    check("add_aluout", ALUOut_WB, 32'h1234);
    check("add_writereg", WriteReg_WB, 5'd3);
    check("add_readdata", ReadData_WB, 32'h0);
    $display("[TB] add -> WB aluout=%h", ALUOut_WB);

    // Store 0xDEADBEEF to 0x10
    clr();
    MemWrite_MEM = 1; ALUOut_MEM = 32'h10; ReadRt_MEM = 32'hDEADBEEF;
    #1 check("sw_stall_first", Stall, 1'b1);
    nxt();
    check("sw_bubble_regwrite", RegWrite_WB, 1'b0);
    check("sw_bubble_aluout", ALUOut_WB, 32'h0);
    check("sw_busy_stall", Stall, 1'b1);
    run_mem("sw", 1);
    check("sw_wb_aluout", ALUOut_WB, 32'h10);
    check("sw_wb_regwrite", RegWrite_WB, 1'b0);
    $display("[TB] sw 0x10 <= DEADBEEF done");

    // Load from 0x13 (same word, low bits ignored)
    clr();
    MemRead_MEM = 1; MemtoReg_MEM = 1; RegWrite_MEM = 1; ALUOut_MEM = 32'h13; WriteReg_MEM = 5'd8;
    #1 run_mem("lw", 2);
    check("lw_readdata", ReadData_WB, 32'hDEADBEEF);
    check("lw_memtoreg", MemtoReg_WB, 1'b1);
    check("lw_regwrite", RegWrite_WB, 1'b1);
    check("lw_writereg", WriteReg_WB, 5'd8);
    $display("[TB] lw 0x13 -> %h", ReadData_WB);

    // Branches
    clr();
    Branch_MEM = 1; PCBranch_MEM = 32'h0000_0400;
    BranchSt_MEM = 3'b000; Zero_MEM = 1;
    #1 check("beq_pcsrc", PCSrc, 1'b1);
    check("beq_flush", Flush, 1'b1);
    check("beq_target", PCBranch, 32'h0000_0400);
    check("beq_nostall", Stall, 1'b0);
    $display("[TB] beq taken=%0b", PCSrc);
    BranchSt_MEM = 3'b001; Zero_MEM = 1;
    #1 check("bne_pcsrc", PCSrc, 1'b0);
    $display("[TB] bne taken=%0b", PCSrc);
    BranchSt_MEM = 3'b011; ALUOut_MEM = 32'h0; Zero_MEM = 1;
    #1 check("bgtz_pcsrc", PCSrc, 1'b0);
    $display("[TB] bgtz taken=%0b", PCSrc);
    BranchSt_MEM = 3'b101; ALUOut_MEM = 32'h8000_0000; Zero_MEM = 0;
    #1 check("bltz_pcsrc", PCSrc, 1'b1);
    check("bltz_flush", Flush, 1'b1);
    $display("[TB] bltz taken=%0b", PCSrc);
    BranchSt_MEM = 3'b110; Zero_MEM = 1;
    #1 check("st110_pcsrc", PCSrc, 1'b0);
    $display("[TB] st110 taken=%0b", PCSrc);
    nxt();

    // Overflowing add: write suppressed, one-cycle exception pulse
    clr();
    RegWrite_MEM = 1; Overflow_MEM = 1; WriteReg_MEM = 5'd5; ALUOut_MEM = 32'h7;
    nxt();
    check("ovf_regwrite", RegWrite_WB, 1'b0);
    check("ovf_exc", OvfExc, 1'b1);
    check("ovf_writereg", WriteReg_WB, 5'd5);
    clr();
    nxt();
    check("ovf_exc_drop", OvfExc, 1'b0);
    $display("[TB] overflow add checked");

    // Overflowing store: no stall, no write
    MemWrite_MEM = 1; Overflow_MEM = 1; ALUOut_MEM = 32'h10; ReadRt_MEM = 32'h1111_1111;
    #1 check("ovfsw_nostall", Stall, 1'b0);
    nxt();
    clr();
    MemRead_MEM = 1; ALUOut_MEM = 32'h10;
    #1 run_mem("ovfsw_lw", 2);
    check("ovfsw_unchanged", ReadData_WB, 32'hDEADBEEF);
    $display("[TB] overflow sw dropped");

    // Address wrap: 0x400 aliases word 0
    clr();
    MemWrite_MEM = 1; ALUOut_MEM = 32'h400; ReadRt_MEM = 32'hCAFE_F00D;
    #1 run_mem("wrap_sw", 2);
    clr();
    MemRead_MEM = 1; ALUOut_MEM = 32'h0;
    #1 run_mem("wrap_lw", 2);
    check("wrap_readdata", ReadData_WB, 32'hCAFE_F00D);
    $display("[TB] wrap lw 0x0 -> %h", ReadData_WB);

    // Reset during BUSY of a store aborts it
    clr();
    MemWrite_MEM = 1; ALUOut_MEM = 32'h10; ReadRt_MEM = 32'h5555_5555;
    #1 check("abort_stall0", Stall, 1'b1);
    nxt();
    check("abort_busy", Stall, 1'b1);
    rst_n = 0;
    #1 check("abort_stall_in_rst", Stall, 1'b0);
    nxt();
    check("abort_aluout", ALUOut_WB, 32'h0);
    rst_n = 1;
    clr();
    #1 check("abort_idle", Stall, 1'b0);
    nxt();
    MemRead_MEM = 1; ALUOut_MEM = 32'h10;
    #1 run_mem("abort_lw", 2);
    check("abort_word_kept", ReadData_WB, 32'hDEADBEEF);
    $display("[TB] reset mid-store checked");

    // MEM_LAT=0 instance: back-to-back sw / lw / add
    clr();
    MemWrite_MEM = 1; ALUOut_MEM = 32'h20; ReadRt_MEM = 32'hA5A5_A5A5;
    #1 check("z_sw_nostall", z_Stall, 1'b0);
    nxt();
    check("z_sw_aluout", z_ALUOut_WB, 32'h20);
    clr();
    MemRead_MEM = 1; MemtoReg_MEM = 1; RegWrite_MEM = 1; ALUOut_MEM = 32'h20; WriteReg_MEM = 5'd9;
    #1 check("z_lw_nostall", z_Stall, 1'b0);
    nxt();
    check("z_lw_readdata", z_ReadData_WB, 32'hA5A5_A5A5);
    check("z_lw_regwrite", z_RegWrite_WB, 1'b1);
    check("z_lw_writereg", z_WriteReg_WB, 5'd9);
    clr();
    RegWrite_MEM = 1; ALUOut_MEM = 32'h99; WriteReg_MEM = 5'd10;
    #1 check("z_add_nostall", z_Stall, 1'b0);
    nxt();
    check("z_add_aluout", z_ALUOut_WB, 32'h99);
    check("z_add_readdata", z_ReadData_WB, 32'h0);
    check("z_add_writereg", z_WriteReg_WB, 5'd10);
    $display("[TB] MEM_LAT=0 back-to-back checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
